// File: rtl/switch_pkg.sv
// Shared definitions for the four-channel switch conditioner.
package switch_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int NUM_SWITCHES     = 4;

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } deb_state_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: two-flop synchroniser, debounce FSM with persistence
// counter, registered level and one-cycle rise/fall pulses.
module debounce_chan
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit INVERT          = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit             ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic          w_in;
  logic          r_sync1;
  logic          r_sync2;
  deb_state_e    r_state;
  deb_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_sw;
  logic          w_sw_nxt;
  logic          r_rise;
  logic          w_rise_nxt;
  logic          r_fall;
  logic          w_fall_nxt;
  logic          w_mismatch;
  logic          w_accept;

  // Polarity is folded in ahead of the synchroniser so that a cleared flop
  // always means "switch not asserted"; an active-low switch held low then
  // debounces to 1 from reset with full synchroniser plus debounce latency.
  assign w_in = i_raw ^ INVERT;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mismatch = (r_sync2 != r_sw);

  // Next-state logic: terminal compare precedes increment, so cnt never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      STABLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (w_mismatch) begin
          if (ONE_SHOT) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = CONFIRM;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_state_nxt = STABLE;
        end
      end
      CONFIRM: begin
        if (!w_mismatch) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == CNT_TERM) begin
          w_accept = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase

    if (w_accept) begin
      w_state_nxt = STABLE;
      w_cnt_nxt   = CNT_ZERO;
      w_sw_nxt    = r_sync2;
      w_rise_nxt  = r_sync2;
      w_fall_nxt  = ~r_sync2;
    end else begin
      w_sw_nxt    = r_sw;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
    end
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= STABLE;
      r_cnt   <= CNT_ZERO;
      r_sw    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sw    <= w_sw_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign o_level = r_sw;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/switch_debounce4.sv
// Four independent debounced switch channels; maps the board-level scalar
// pins onto channel indices 0..3.
module switch_debounce4
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit INVERT          = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    SWITCH1,
  input  logic                    SWITCH2,
  input  logic                    SWITCH3,
  input  logic                    SWITCH4,
  output logic                    SW1,
  output logic                    SW2,
  output logic                    SW3,
  output logic                    SW4,
  output logic [NUM_SWITCHES-1:0] RISE,
  output logic [NUM_SWITCHES-1:0] FALL
);

  logic [NUM_SWITCHES-1:0] w_raw;
  logic [NUM_SWITCHES-1:0] w_level;
  logic [NUM_SWITCHES-1:0] w_rise;
  logic [NUM_SWITCHES-1:0] w_fall;

  assign w_raw = {SWITCH4, SWITCH3, SWITCH2, SWITCH1};

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT)
    ) u_chan (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  assign SW1  = w_level[0];
  assign SW2  = w_level[1];
  assign SW3  = w_level[2];
  assign SW4  = w_level[3];
  assign RISE = w_rise;
  assign FALL = w_fall;

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed bench: DEBOUNCE_CYCLES=4 with one INVERT=0 and one INVERT=1 instance.
module tb_switch_debounce4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_a;
  logic [3:0] sw_b;
  logic       a_sw1, a_sw2, a_sw3, a_sw4;
  logic       b_sw1, b_sw2, b_sw3, b_sw4;
  logic [3:0] a_rise, a_fall, b_rise, b_fall;
  logic [3:0] a_lvl, b_lvl;
  int         tests_run;
  int         tests_failed;

  assign a_lvl = {a_sw4, a_sw3, a_sw2, a_sw1};
  assign b_lvl = {b_sw4, b_sw3, b_sw2, b_sw1};

  switch_debounce4 #(.DEBOUNCE_CYCLES(4), .INVERT(1'b0)) u_dut_a (
    .CLK(clk), .RST_N(rst_n),
    .SWITCH1(sw_a[0]), .SWITCH2(sw_a[1]), .SWITCH3(sw_a[2]), .SWITCH4(sw_a[3]),
    .SW1(a_sw1), .SW2(a_sw2), .SW3(a_sw3), .SW4(a_sw4),
    .RISE(a_rise), .FALL(a_fall)
  );

  switch_debounce4 #(.DEBOUNCE_CYCLES(4), .INVERT(1'b1)) u_dut_b (
    .CLK(clk), .RST_N(rst_n),
    .SWITCH1(sw_b[0]), .SWITCH2(sw_b[1]), .SWITCH3(sw_b[2]), .SWITCH4(sw_b[3]),
    .SW1(b_sw1), .SW2(b_sw2), .SW3(b_sw3), .SW4(b_sw4),
    .RISE(b_rise), .FALL(b_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b1;
    sw_a  = 4'b0000;
    sw_b  = 4'b0000;
    #2 rst_n = 1'b0;
    step(2);
    check("reset_a", {a_lvl, a_rise, a_fall}, 12'h000);
    check("reset_b", {b_lvl, b_rise, b_fall}, 12'h000);
    rst_n = 1'b1;

    // INVERT=1 instance: pins held low from reset are asserted.
    step(5);
    check("inv_pre", {b_lvl, b_rise}, {4'b0000, 4'b0000});
    step(1);
    check("inv_rise", {b_lvl, b_rise, b_fall}, {4'b1111, 4'b1111, 4'b0000});
    step(1);
    check("inv_rise_end", {b_lvl, b_rise}, {4'b1111, 4'b0000});

    // Clean step on channel 0.
    sw_a[0] = 1'b1;
    step(5);
    check("clean_pre", {a_lvl, a_rise}, {4'b0000, 4'b0000});
    step(1);
    check("clean_rise", {a_lvl, a_rise, a_fall}, {4'b0001, 4'b0001, 4'b0000});
    step(1);
    check("clean_rise_end", {a_lvl, a_rise}, {4'b0001, 4'b0000});
    step(13);
    check("clean_hold", {a_lvl, a_rise, a_fall}, {4'b0001, 4'b0000, 4'b0000});

    // Bounce on channel 1: 1,0,1,0 for 2 cycles each, then held 1.
    for (int i = 0; i < 8; i++) begin
      sw_a[1] = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      step(1);
      check("bounce_quiet", {a_lvl, a_rise, a_fall}, {4'b0001, 4'b0000, 4'b0000});
    end
    sw_a[1] = 1'b1;
    step(5);
    check("bounce_pre", {a_lvl, a_rise}, {4'b0001, 4'b0000});
    step(1);
    check("bounce_rise", {a_lvl, a_rise}, {4'b0011, 4'b0010});
    step(1);
    check("bounce_rise_end", {a_lvl, a_rise}, {4'b0011, 4'b0000});

    // Glitch on channel 2 shorter than the debounce window.
    sw_a[2] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) sw_a[2] = 1'b0;
      step(1);
      check("glitch_quiet", {a_lvl, a_rise, a_fall}, {4'b0011, 4'b0000, 4'b0000});
    end

    // Settle all low, then simultaneous rise and fall on all channels.
    sw_a = 4'b0000;
    step(5);
    check("settle_pre", {a_lvl, a_fall}, {4'b0011, 4'b0000});
    step(1);
    check("settle_fall", {a_lvl, a_rise, a_fall}, {4'b0000, 4'b0000, 4'b0011});
    step(1);
    sw_a = 4'b1111;
    step(5);
    check("simul_pre", {a_lvl, a_rise}, {4'b0000, 4'b0000});
    step(1);
    check("simul_rise", {a_lvl, a_rise, a_fall}, {4'b1111, 4'b1111, 4'b0000});
    step(1);
    check("simul_rise_end", {a_lvl, a_rise}, {4'b1111, 4'b0000});
    step(3);
    sw_a = 4'b0000;
    step(5);
    check("simul_fall_pre", {a_lvl, a_fall}, {4'b1111, 4'b0000});
    step(1);
    check("simul_fall", {a_lvl, a_rise, a_fall}, {4'b0000, 4'b0000, 4'b1111});
    step(1);
    check("simul_fall_end", {a_lvl, a_fall}, {4'b0000, 4'b0000});

    // Reset in the middle of a channel-3 count, with channel 0 already high.
    sw_a[0] = 1'b1;
    step(7);
    check("rst_setup", {a_lvl, a_rise}, {4'b0001, 4'b0000});
    sw_a[3] = 1'b1;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_a", {a_lvl, a_rise, a_fall}, 12'h000);
    check("rst_async_b", {b_lvl, b_rise, b_fall}, 12'h000);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("rst_relatch_pre", {a_lvl, b_lvl}, {4'b0000, 4'b0000});
    step(1);
    check("rst_relatch_a", {a_lvl, a_rise, a_fall}, {4'b1001, 4'b1001, 4'b0000});
    check("rst_relatch_b", {b_lvl, b_rise, b_fall}, {4'b1111, 4'b1111, 4'b0000});
    step(1);

    // INVERT=1: releasing channel 0 (pin high) yields a fall pulse.
    sw_b[0] = 1'b1;
    step(5);
    check("inv_fall_pre", {b_lvl, b_fall}, {4'b1111, 4'b0000});
    step(1);
    check("inv_fall", {b_lvl, b_rise, b_fall}, {4'b1110, 4'b0000, 4'b0001});
    step(1);
    check("inv_fall_end", {b_lvl, b_fall, a_lvl}, {4'b1110, 4'b0000, 4'b1001});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
